alu_iter: RTL



---
 rtl/alu_iter_if.sv | 36 +++
 rtl/alu_iter.sv | 108 ++++++++++
 2 files changed

// File: rtl/alu_iter_if.sv
// Handshake and operand bundle between the multicycle datapath and alu_iter.
// The datapath side is the master and the ALU side is the slave.
interface alu_iter_if #(
    parameter int W = 32
);
    logic         start;
    logic [2:0]   gout;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;
    logic         done;

    modport master (
        output start,
        output gout,
        output a,
        output b,
        input  result,
        input  zero,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  gout,
        input  a,
        input  b,
        output result,
        output zero,
        output busy,
        output done
    );
endinterface

// File: rtl/alu_iter.sv
// Sequential ALU: single-cycle ops complete on the acceptance edge, while the
// variable left shift (sllv) walks one bit position per cycle so that the
// datapath can stall on it instead of paying for a barrel shifter.
module alu_iter #(
    parameter int W = 32
) (
    input logic       clk,
    input logic       reset,
    alu_iter_if.slave bus
);
    localparam int SW = $clog2(W);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam logic [2:0] OP_SLLV = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    logic [0:0]    state;
    logic [SW-1:0] cnt;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_next;
    logic [W-1:0]  op_res;
    logic [SW-1:0] amt;
    logic          accept;
    logic          shift_req;

    // Single-cycle result for every code. The sllv entry only ever completes
    // here with a zero count, so it is simply operand B.
    function automatic logic [W-1:0] alu_op(
        input logic [2:0]   code,
        input logic [W-1:0] x,
        input logic [W-1:0] y
    );
        logic signed [W-1:0] sx;
        logic signed [W-1:0] sy;
        sx = $signed(x);
        sy = $signed(y);
        case (code)
            OP_ADD:  alu_op = x + y;
            OP_SUB:  alu_op = x - y;
            OP_AND:  alu_op = x & y;
            OP_OR:   alu_op = x | y;
            OP_SLT:  alu_op = {{(W-1){1'b0}}, (sx < sy)};
            OP_PASS: alu_op = x;
            OP_SLLV: alu_op = y;
            default: alu_op = '0;
        endcase
    endfunction

    assign bus.busy  = (state == SHIFT);
    assign accept    = bus.start && (state == IDLE);
    assign amt       = bus.a[SW-1:0];
    assign shift_req = (bus.gout == OP_SLLV) && (amt != '0);
    assign op_res    = alu_op(bus.gout, bus.a, bus.b);
    assign acc_next  = {acc[W-2:0], 1'b0};

    // Control: state, shift count and the registered result/zero/done outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bus.result <= '0;
            bus.zero   <= 1'b1;
            bus.done   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (shift_req) begin
                            cnt   <= amt;
                            state <= SHIFT;
                        end else begin
                            bus.result <= op_res;
                            bus.zero   <= (op_res == '0);
                            bus.done   <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    cnt <= cnt - SW'(1);
                    if (cnt == SW'(1)) begin
                        bus.result <= acc_next;
                        bus.zero   <= (acc_next == '0);
                        bus.done   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift accumulator: loaded with operand B on acceptance, then one bit per cycle.
    always_ff @(posedge clk) begin
        if (accept && shift_req) begin
            acc <= bus.b;
        end else if (state == SHIFT) begin
            acc <= acc_next;
        end
    end
endmodule
